// File: rtl/ak4619_codec_model_if.sv
// Pin bundle between the FPGA-side TDM128 master and the AK4619 CODEC model.
// The CODEC side uses the slave modport; dbg_* expose the model's FSM state and phase.
interface ak4619_codec_model_if #(
  parameter int W = 16
);
  logic                pdn;
  logic                bick;
  logic                lrck;
  logic                sdin;
  logic                sdout;
  logic signed [W-1:0] adc_in0;
  logic signed [W-1:0] adc_in1;
  logic signed [W-1:0] adc_in2;
  logic signed [W-1:0] adc_in3;
  logic signed [W-1:0] dac_out0;
  logic signed [W-1:0] dac_out1;
  logic signed [W-1:0] dac_out2;
  logic signed [W-1:0] dac_out3;
  // dac_valid qualifies dac_out0..3 for exactly one cycle; there is no ready, the
  // consumer takes the words then (they stay stable until the next delivery).
  logic                dac_valid;
  logic                locked;
  logic                sync_err;
  logic                dbg_state;
  logic [7:0]          dbg_phase;

  modport master (
    output pdn, bick, lrck, sdin, adc_in0, adc_in1, adc_in2, adc_in3,
    input  sdout, dac_out0, dac_out1, dac_out2, dac_out3,
    input  dac_valid, locked, sync_err, dbg_state, dbg_phase
  );

  modport slave (
    input  pdn, bick, lrck, sdin, adc_in0, adc_in1, adc_in2, adc_in3,
    output sdout, dac_out0, dac_out1, dac_out2, dac_out3,
    output dac_valid, locked, sync_err, dbg_state, dbg_phase
  );
endinterface

// File: rtl/ak4619_codec_model.sv
// AK4619 TDM128 CODEC-side responder: deserializes 4 DAC slots, serializes 4 ADC slots.
// Optional CODEC_LOOPBACK_EN: retransmit the previous frame's received words instead of adc_in0..3.
module ak4619_codec_model #(
  parameter int W = 16
) (
  input logic                clk_256fs,
  input logic                rst,
  ak4619_codec_model_if.slave bus
);
  typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} state_e;

  localparam logic [W-1:0] ONE = W'(1);

  state_e     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic       lrck_q, lrck_d;
  logic       sdout_q, sdout_d;
  logic       dv_q, dv_d;
  logic       serr_q, serr_d;
  logic [W-1:0] rx_q  [4];
  logic [W-1:0] rx_d  [4];
  logic [W-1:0] tx_q  [4];
  logic [W-1:0] tx_d  [4];
  logic [W-1:0] dac_q [4];
  logic [W-1:0] dac_d [4];
  logic [W-1:0] src   [4];

  logic       fall, mismatch, active, in_slot;
  logic [7:0] p_cur;
  logic [1:0] ch;
  logic [4:0] bit_n;
  logic [5:0] pos;
  logic [W-1:0] tx_sh;

  always_comb begin
    fall     = lrck_q & ~bus.lrck;
    mismatch = (bus.bick != p_q[0]) || (bus.lrck != p_q[7]);
    // A lrck fall defines phase 0 regardless of where the counter was.
    p_cur    = fall ? 8'd0 : p_q;
    ch       = p_cur[7:6];
    bit_n    = p_cur[5:1];
    in_slot  = ({1'b0, bit_n} < 6'(W));
    pos      = 6'(W - 1) - {1'b0, bit_n};
    tx_sh    = tx_q[ch] >> pos;

`ifdef CODEC_LOOPBACK_EN
    src = rx_q;
`else
    src[0] = bus.adc_in0;
    src[1] = bus.adc_in1;
    src[2] = bus.adc_in2;
    src[3] = bus.adc_in3;
`endif

    state_d = state_q;
    p_d     = 8'd0;
    lrck_d  = bus.lrck;
    sdout_d = sdout_q;
    dv_d    = 1'b0;
    serr_d  = 1'b0;
    rx_d    = rx_q;
    tx_d    = tx_q;
    dac_d   = dac_q;
    active  = 1'b0;

    if (!bus.pdn) begin
      // Power-down looks like reset except dac_out keeps its last words.
      state_d = S_UNLOCKED;
      lrck_d  = 1'b0;
      sdout_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
        rx_d[i] = '0;
        tx_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_UNLOCKED: begin
          sdout_d = 1'b0;
          if (fall) begin
            state_d = S_LOCKED;
            active  = 1'b1;
          end
        end
        S_LOCKED: begin
          if (mismatch) begin
            serr_d  = 1'b1;
            sdout_d = 1'b0;
            if (fall) active = 1'b1;
            else      state_d = S_UNLOCKED;
          end else begin
            active = 1'b1;
          end
        end
        default: state_d = S_UNLOCKED;
      endcase

      if (active) begin
        p_d = p_cur + 8'd1;
        if (bus.bick && in_slot)
          rx_d[ch] = (rx_q[ch] & ~(ONE << pos)) | (W'(bus.sdin) << pos);
        if (p_cur == 8'd255) begin
          dac_d = rx_d;
          dv_d  = 1'b1;
        end
        // sdout only moves at the end of bick=0 cycles so the master sees it settled.
        if (p_cur == 8'd0) begin
          tx_d    = src;
          sdout_d = src[0][W-1];
        end else if (!p_cur[0]) begin
          sdout_d = in_slot ? tx_sh[0] : 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      state_q <= S_UNLOCKED;
      p_q     <= 8'd0;
      lrck_q  <= 1'b0;
      sdout_q <= 1'b0;
      dv_q    <= 1'b0;
      serr_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rx_q[i]  <= '0;
        tx_q[i]  <= '0;
        dac_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      lrck_q  <= lrck_d;
      sdout_q <= sdout_d;
      dv_q    <= dv_d;
      serr_q  <= serr_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      dac_q   <= dac_d;
    end
  end

  assign bus.sdout     = sdout_q;
  assign bus.dac_out0  = dac_q[0];
  assign bus.dac_out1  = dac_q[1];
  assign bus.dac_out2  = dac_q[2];
  assign bus.dac_out3  = dac_q[3];
  assign bus.dac_valid = dv_q;
  assign bus.locked    = (state_q == S_LOCKED);
  assign bus.sync_err  = serr_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_phase = p_q;
endmodule
